onectr_arbiter: RTL and testbench

Shares one onectr ones-counter instance between NREQ requesters.
- Round-robin selection among pending requests; captures the winner's word and sequences the counter (start pulse, fixed wait).
- Samples the result and returns it tagged with the requester index.
- Sits between client blocks and the onectr datapath; onectr connects to the ctr_* ports.

---
 rtl/onectr_arbiter_pkg.sv | 19 +
 rtl/onectr_arbiter_rr.sv | 55 +++++
 rtl/onectr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_onectr_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onectr_arbiter_pkg.sv
// Shared definitions for the onectr arbiter slice.
// Contents: FSM state encodings, the jobs counter width, and a width helper
// for sizing id and count fields.
package onectr_arb_pkg;

    localparam int unsigned JOBS_W = 16;

    // FSM encodings
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // Bits needed to index n items, never less than one
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/onectr_arbiter_rr.sv
// Round-robin arbiter: picks the first pending request scanning upward from
// the slot after the last winner. The winner is combinational; the pointer
// only advances when the caller accepts the winner.
// Ports:
//   clk, rst          clock, async active-low reset
//   req_i             per-requester request
//   accept_i          caller takes the current winner this cycle
//   win_valid_c_o     some request is pending (combinational)
//   win_id_c_o        winner index (combinational)
//   win_oh_c_o        winner one-hot (combinational)
module rr_arbiter
    import onectr_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_i,
    input  logic                        accept_i,
    output logic                        win_valid_c_o,
    output logic [width_of(NREQ)-1:0]   win_id_c_o,
    output logic [NREQ-1:0]             win_oh_c_o
);

    localparam int unsigned IDW = width_of(NREQ);

    logic [IDW-1:0] ptr_q;
    int             idx;

    // Scan from far to near so the nearest pending slot after ptr wins
    always_comb begin
        win_valid_c_o = 1'b0;
        win_id_c_o    = '0;
        idx           = 0;
        for (int i = int'(NREQ); i > 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (req_i[IDW'(idx)]) begin
                win_valid_c_o = 1'b1;
                win_id_c_o    = IDW'(idx);
            end
        end
        win_oh_c_o = win_valid_c_o ? (NREQ'(1) << win_id_c_o) : '0;
    end

    // Reset to the last slot so requester 0 has first priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= IDW'(NREQ - 1);
        end else if (accept_i && win_valid_c_o) begin
            ptr_q <= win_id_c_o;
        end
    end

endmodule

// File: rtl/onectr_arbiter.sv
// Shares one onectr ones-counter between NREQ requesters. One job in flight:
// arbitrate, capture the winner's word, pulse the counter start, wait a fixed
// latency, sample the count and return it tagged with the requester id.
// Optional feature macro: ONECTR_ARB_STATS_EN (jobs_o counts completed jobs;
// tied to zero when undefined).
// Ports:
//   clk, rst              clock, async active-low reset
//   req_i, req_data_i     requests and packed request words
//   gnt_o                 one-cycle one-hot grant
//   busy_o                job in progress
//   ctr_start_o           start pulse to onectr
//   ctr_inport_o          word under count, zero when idle
//   ctr_outport_i         count from onectr
//   resp_valid_o          one-cycle result strobe
//   resp_id_o             requester index of result
//   resp_count_o          ones count of result
//   jobs_o                completed-job counter
module onectr_arbiter
    import onectr_arb_pkg::*;
#(
    parameter int unsigned INPUTSIZE   = 64,
    parameter int unsigned NREQ        = 4,
    parameter int unsigned CTR_LATENCY = INPUTSIZE + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req_i,
    input  logic [NREQ*INPUTSIZE-1:0]           req_data_i,
    output logic [NREQ-1:0]                     gnt_o,
    output logic                                busy_o,
    output logic                                ctr_start_o,
    output logic [INPUTSIZE-1:0]                ctr_inport_o,
    input  logic [width_of(INPUTSIZE+1)-1:0]    ctr_outport_i,
    output logic                                resp_valid_o,
    output logic [width_of(NREQ)-1:0]           resp_id_o,
    output logic [width_of(INPUTSIZE+1)-1:0]    resp_count_o,
    output logic [JOBS_W-1:0]                   jobs_o
);

    localparam int unsigned CW  = width_of(INPUTSIZE + 1);
    localparam int unsigned IDW = width_of(NREQ);
    localparam int unsigned WW  = width_of(CTR_LATENCY);

    logic [1:0]           state_q, state_d;
    logic [INPUTSIZE-1:0] data_q, data_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [IDW-1:0]       resp_id_q, resp_id_d;
    logic [CW-1:0]        resp_count_q, resp_count_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic                 resp_valid_q, resp_valid_d;

    logic                 accept_c;
    logic                 win_valid_c;
    logic [IDW-1:0]       win_id_c;
    logic [NREQ-1:0]      win_oh_c;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .accept_i      (accept_c),
        .win_valid_c_o (win_valid_c),
        .win_id_c_o    (win_id_c),
        .win_oh_c_o    (win_oh_c)
    );

    // Next-state and registered-output decode
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        id_d         = id_q;
        resp_id_d    = resp_id_q;
        resp_count_d = resp_count_q;
        wait_d       = wait_q;
        gnt_d        = '0;
        start_d      = 1'b0;
        resp_valid_d = 1'b0;
        accept_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_valid_c) begin
                    accept_c = 1'b1;
                    data_d   = req_data_i[32'(win_id_c) * INPUTSIZE +: INPUTSIZE];
                    id_d     = win_id_c;
                    gnt_d    = win_oh_c;
                    start_d  = 1'b1;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wait_d  = WW'(CTR_LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    resp_count_d = ctr_outport_i;
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    wait_d = wait_q - WW'(1);
                end
            end
            S_RESP: begin
                // Clearing the word makes ctr_inport_o read zero in IDLE
                data_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            data_q       <= '0;
            id_q         <= '0;
            resp_id_q    <= '0;
            resp_count_q <= '0;
            wait_q       <= '0;
            gnt_q        <= '0;
            busy_q       <= 1'b0;
            start_q      <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            id_q         <= id_d;
            resp_id_q    <= resp_id_d;
            resp_count_q <= resp_count_d;
            wait_q       <= wait_d;
            gnt_q        <= gnt_d;
            busy_q       <= busy_d;
            start_q      <= start_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign busy_o       = busy_q;
    assign ctr_start_o  = start_q;
    assign ctr_inport_o = data_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_count_o = resp_count_q;

`ifdef ONECTR_ARB_STATS_EN
    logic [JOBS_W-1:0] jobs_q;

    // Count each RESP cycle; wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jobs_q <= '0;
        end else if (resp_valid_q) begin
            jobs_q <= jobs_q + JOBS_W'(1);
        end
    end

    assign jobs_o = jobs_q;
`else
    assign jobs_o = '0;
`endif

endmodule

// File: tb/tb_onectr_arbiter.sv
// Directed bench for onectr_arbiter with a behavioural onectr model and a
// scoreboard of expected responses (id, count, arrival cycle).
module tb_onectr_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 64;
    localparam int unsigned L    = W + 1;
    localparam int unsigned CW   = 7;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_i;
    logic [NREQ*W-1:0]    req_data_i;
    logic [NREQ-1:0]      gnt_o;
    logic                 busy_o;
    logic                 ctr_start_o;
    logic [W-1:0]         ctr_inport_o;
    logic [CW-1:0]        ctr_outport_i;
    logic                 resp_valid_o;
    logic [1:0]           resp_id_o;
    logic [CW-1:0]        resp_count_o;
    logic [15:0]          jobs_o;

    onectr_arbiter #(.INPUTSIZE(W), .NREQ(NREQ), .CTR_LATENCY(L)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .req_data_i    (req_data_i),
        .gnt_o         (gnt_o),
        .busy_o        (busy_o),
        .ctr_start_o   (ctr_start_o),
        .ctr_inport_o  (ctr_inport_o),
        .ctr_outport_i (ctr_outport_i),
        .resp_valid_o  (resp_valid_o),
        .resp_id_o     (resp_id_o),
        .resp_count_o  (resp_count_o),
        .jobs_o        (jobs_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // onectr model: count is valid only for the edge CTR_LATENCY edges after start
    logic          m_act;
    int unsigned   m_lat;
    logic [CW-1:0] m_pop;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act <= 1'b0;
            m_lat <= 0;
            m_pop <= '0;
        end else if (ctr_start_o) begin
            m_act <= 1'b1;
            m_lat <= L - 1;
            m_pop <= CW'($countones(ctr_inport_o));
        end else if (m_act) begin
            if (m_lat == 0) m_act <= 1'b0;
            else            m_lat <= m_lat - 1;
        end
    end
    assign ctr_outport_i = (m_act && m_lat == 0) ? m_pop : '1;

    typedef struct {
        int id;
        int cnt;
        int cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] jobs_exp = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Response monitor and always-on invariants
    always @(negedge clk) begin
        chk("gnt_onehot", 64'($countones(gnt_o) <= 1), 64'd1);
        chk("start_resp_excl", 64'(ctr_start_o & resp_valid_o), 64'd0);
        if (resp_valid_o) begin
            if (q.size() == 0) begin
                chk("resp_spurious", 64'(resp_valid_o), 64'd0);
            end else begin
                e = q.pop_front();
                chk("resp_id", 64'(resp_id_o), 64'(e.id));
                chk("resp_count", 64'(resp_count_o), 64'(e.cnt));
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic set_word(input int k, input logic [63:0] w);
        req_data_i[k*W +: W] = w;
    endtask

    task automatic chk_jobs();
`ifdef ONECTR_ARB_STATS_EN
        chk("jobs", 64'(jobs_o), 64'(jobs_exp));
`else
        chk("jobs", 64'(jobs_o), 64'd0);
`endif
    endtask

    task automatic apply_reset();
        rst   = 1'b0;
        req_i = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(gnt_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_start", 64'(ctr_start_o), 64'd0);
        chk("rst_inport", 64'(ctr_inport_o), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_resp_id", 64'(resp_id_o), 64'd0);
        chk("rst_resp_count", 64'(resp_count_o), 64'd0);
        chk("rst_jobs", 64'(jobs_o), 64'd0);
        q.delete();
        jobs_exp = '0;
        rst = 1'b1;
    endtask

    // Expect no grant for n-1 cycles, then the given grant with its launch
    task automatic expect_grant(input int n, input int id, input logic [63:0] word);
        logic [63:0] oh;
        oh = 64'd1 << id;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            chk("gnt_quiet", 64'(gnt_o), 64'd0);
        end
        @(negedge clk);
        chk("gnt", 64'(gnt_o), oh);
        chk("start", 64'(ctr_start_o), 64'd1);
        chk("inport", ctr_inport_o, word);
        chk("busy_launch", 64'(busy_o), 64'd1);
        q.push_back('{id: id, cnt: $countones(word), cyc: cyc + 1 + int'(L)});
        jobs_exp = jobs_exp + 16'd1;
    endtask

    // From the grant cycle (plus 'done' cycles already spent), reach IDLE and check held results
    task automatic wait_idle(input int done, input int id, input int cnt);
        for (int i = done; i < int'(L) + 2; i++) begin
            @(negedge clk);
            chk("gnt_quiet", 64'(gnt_o), 64'd0);
        end
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_inport", 64'(ctr_inport_o), 64'd0);
        chk("held_resp_id", 64'(resp_id_o), 64'(id));
        chk("held_resp_count", 64'(resp_count_o), 64'(cnt));
        chk("resp_pending", 64'(q.size()), 64'd0);
        chk_jobs();
    endtask

    initial begin
        rst        = 1'b0;
        req_i      = '0;
        req_data_i = '0;
        apply_reset();

        // Single request: 0xFF -> count 8
        set_word(0, 64'hFF);
        req_i = 4'b0001;
        expect_grant(1, 0, 64'hFF);
        req_i = '0;
        wait_idle(0, 0, 8);

        // All requesting continuously: order 0,1,2,3,0
        apply_reset();
        for (int k = 0; k < int'(NREQ); k++) set_word(k, '1);
        req_i = 4'b1111;
        expect_grant(1, 0, '1);
        expect_grant(int'(L) + 3, 1, '1);
        expect_grant(int'(L) + 3, 2, '1);
        expect_grant(int'(L) + 3, 3, '1);
        expect_grant(int'(L) + 3, 0, '1);
        req_i = '0;
        wait_idle(0, 0, 64);

        // Out of reset with 1010: 1, 3, 1
        apply_reset();
        set_word(1, 64'h0F);
        set_word(3, 64'hFFFF);
        req_i = 4'b1010;
        expect_grant(1, 1, 64'h0F);
        expect_grant(int'(L) + 3, 3, 64'hFFFF);
        expect_grant(int'(L) + 3, 1, 64'h0F);
        req_i = '0;
        wait_idle(0, 1, 4);

        // Reset in the middle of WAIT: job aborted, then requester 2 served
        set_word(0, 64'hF0F0);
        req_i = 4'b0001;
        expect_grant(1, 0, 64'hF0F0);
        req_i = '0;
        repeat (10) @(negedge clk);
        apply_reset();
        for (int i = 0; i < int'(L) + 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 64'(gnt_o), 64'd0);
        end
        set_word(2, 64'h3);
        req_i = 4'b0100;
        expect_grant(1, 2, 64'h3);
        req_i = '0;
        wait_idle(0, 2, 2);

        // Request pulsed while busy is lost
        set_word(0, 64'h7);
        set_word(2, 64'hFFFF_FFFF);
        req_i = 4'b0001;
        expect_grant(1, 0, 64'h7);
        req_i = '0;
        repeat (5) @(negedge clk);
        req_i = 4'b0100;
        @(negedge clk);
        req_i = '0;
        wait_idle(6, 0, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lost_req_quiet", 64'(gnt_o), 64'd0);
        end

`ifdef ONECTR_ARB_STATS_EN
        // Job counter wraps from 0xFFFF
        force dut.jobs_q = 16'hFFFF;
        @(negedge clk);
        release dut.jobs_q;
        jobs_exp = 16'hFFFF;
        chk_jobs();
        req_i = 4'b0001;
        expect_grant(1, 0, 64'h7);
        req_i = '0;
        wait_idle(0, 0, 3);
        req_i = 4'b0001;
        expect_grant(1, 0, 64'h7);
        req_i = '0;
        wait_idle(0, 0, 3);
        chk("jobs_wrap", 64'(jobs_o), 64'd1);
`endif

        chk("final_queue_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
